// File: rtl/dp_fifo_par.sv
// rtl/dp_fifo_par.sv - single-clock FIFO on inferred dual-port RAM with per-lane parity
module dp_fifo_par #(
    parameter int WIDTH        = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int PAR_WIDTH    = 4,
    parameter int PARITY_ODD   = 0,
    parameter int ALMOST_FULL  = 1020,
    parameter int ALMOST_EMPTY = 4
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic [WIDTH-1:0]      Data,
    input  logic                  WrEn,
    input  logic [PAR_WIDTH-1:0]  EDI,
    input  logic                  RdEn,
    output logic [WIDTH-1:0]      Q,
    output logic [PAR_WIDTH-1:0]  EDO,
    output logic                  QValid,
    output logic                  Full,
    output logic                  Empty,
    output logic                  AlmostFull,
    output logic                  AlmostEmpty,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Overflow,
    output logic                  Underflow,
    input  logic                  ClrErr,
    output logic                  ParErr,
    output logic [PAR_WIDTH-1:0]  ParErrLane
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LANE  = WIDTH / PAR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = CW'(ALMOST_FULL);
    localparam logic [ADDR_WIDTH:0] AE_C    = CW'(ALMOST_EMPTY);

    // Per-lane parity of a data word; odd mode inverts every lane bit.
    function automatic logic [PAR_WIDTH-1:0] lane_par(input logic [WIDTH-1:0] d);
        logic [PAR_WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < PAR_WIDTH; i++) begin
            p[i] = (^d[i*LANE +: LANE]) ^ (PARITY_ODD != 0);
        end
        return p;
    endfunction

    logic [PAR_WIDTH+WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]  count_q, count_d;
    logic                 full_q, empty_q, af_q, ae_q;
    logic [WIDTH-1:0]     q_q;
    logic [PAR_WIDTH-1:0] edo_q;
    logic                 qvalid_q, ovf_q, unf_q;
    logic [PAR_WIDTH-1:0] lane_q, lane_d, mismatch;
    logic                 wr_acc, rd_acc;

    // Acceptance uses the registered flags, so a full FIFO never writes and an empty one never reads.
    assign wr_acc = WrEn & ~full_q;
    assign rd_acc = RdEn & ~empty_q;

    // Next pointers, occupancy from the wrap-bit pointer difference, and sticky parity state.
    always_comb begin
        wptr_d   = wptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
        rptr_d   = rptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
        count_d  = wptr_d - rptr_d;
        mismatch = qvalid_q ? (lane_par(q_q) ^ edo_q) : '0;
        lane_d   = ClrErr ? mismatch : (lane_q | mismatch);
    end

    // RAM write port; contents survive reset and are overwritten only by accepted writes.
    always_ff @(posedge Clock) begin
        if (wr_acc) begin
            mem_q[wptr_q[ADDR_WIDTH-1:0]] <= {lane_par(Data) ^ EDI, Data};
        end
    end

    // Registered read port, flags and event pulses.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            q_q      <= '0;
            edo_q    <= '0;
            qvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            lane_q   <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_C);
            empty_q  <= (count_d == '0);
            af_q     <= (count_d >= AF_C);
            ae_q     <= (count_d <= AE_C);
            if (rd_acc) begin
                {edo_q, q_q} <= mem_q[rptr_q[ADDR_WIDTH-1:0]];
            end
            qvalid_q <= rd_acc;
            ovf_q    <= WrEn & full_q;
            unf_q    <= RdEn & empty_q;
            lane_q   <= lane_d;
        end
    end

    assign Q           = q_q;
    assign EDO         = edo_q;
    assign QValid      = qvalid_q;
    assign Full        = full_q;
    assign Empty       = empty_q;
    assign AlmostFull  = af_q;
    assign AlmostEmpty = ae_q;
    assign Count       = count_q;
    assign Overflow    = ovf_q;
    assign Underflow   = unf_q;
    assign ParErrLane  = lane_q;
    assign ParErr      = |lane_q;

endmodule

// File: tb/tb_dp_fifo_par.sv
// tb/tb_dp_fifo_par.sv - self-checking bench for dp_fifo_par
module tb_dp_fifo_par;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic [31:0] Data = '0;
    logic        WrEn = 1'b0;
    logic [3:0]  EDI = '0;
    logic        RdEn = 1'b0;
    logic [31:0] Q;
    logic [3:0]  EDO;
    logic        QValid, Full, Empty, AlmostFull, AlmostEmpty;
    logic [10:0] Count;
    logic        Overflow, Underflow;
    logic        ClrErr = 1'b0;
    logic        ParErr;
    logic [3:0]  ParErrLane;

    int n_chk = 0;
    int n_fail = 0;

    dp_fifo_par dut (
        .Clock(Clock), .ResetN(ResetN), .Data(Data), .WrEn(WrEn), .EDI(EDI),
        .RdEn(RdEn), .Q(Q), .EDO(EDO), .QValid(QValid), .Full(Full),
        .Empty(Empty), .AlmostFull(AlmostFull), .AlmostEmpty(AlmostEmpty),
        .Count(Count), .Overflow(Overflow), .Underflow(Underflow),
        .ClrErr(ClrErr), .ParErr(ParErr), .ParErrLane(ParErrLane)
    );

    always #5 Clock = ~Clock;

    // Even parity per byte lane, counted from the number of set bits.
    function automatic logic [3:0] ref_par(input logic [31:0] d);
        logic [3:0] p;
        logic [7:0] b;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            b = d[8*i +: 8];
            p[i] = ($countones(b) % 2) == 1;
        end
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic wr, input logic rd, input logic [31:0] d,
                       input logic [3:0] edi, input logic clr);
        WrEn = wr; RdEn = rd; Data = d; EDI = edi; ClrErr = clr;
        @(posedge Clock);
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] data;
        logic [31:0] q;
        logic        qv;
        logic [10:0] cnt;
        logic        emp;
        logic        ae;
    } vec_t;

    vec_t tv[11];
    logic [31:0] mq[$];
    logic [31:0] expq;
    logic        wr, rd, wacc, racc;
    logic [31:0] d;
    int          pw, pr;

    initial begin
        for (int i = 0; i < 5; i++)
            tv[i] = '{1'b1, 1'b0, 32'(i + 1), 32'h0, 1'b0, 11'(i + 1), 1'b0, (i + 1) <= 4};
        for (int i = 0; i < 5; i++)
            tv[5 + i] = '{1'b0, 1'b1, 32'h0, 32'(i + 1), 1'b1, 11'(4 - i), (i == 4), 1'b1};
        tv[10] = '{1'b0, 1'b0, 32'h0, 32'h5, 1'b0, 11'd0, 1'b1, 1'b1};

        #23 ResetN = 1'b1;
        chk("rst_count", Count, 0);
        chk("rst_empty", Empty, 1);
        chk("rst_ae", AlmostEmpty, 1);
        chk("rst_full", Full, 0);
        chk("rst_af", AlmostFull, 0);
        chk("rst_q", {EDO, Q}, 0);
        chk("rst_pulses", {QValid, Overflow, Underflow}, 0);
        chk("rst_parerr", {ParErr, ParErrLane}, 0);

        // Basic write 1..5 then read back with RdEn held.
        for (int i = 0; i < 11; i++) begin
            cyc(tv[i].wr, tv[i].rd, tv[i].data, 4'h0, 1'b0);
            chk($sformatf("tv%0d_q", i), Q, tv[i].q);
            chk($sformatf("tv%0d_qv", i), QValid, tv[i].qv);
            chk($sformatf("tv%0d_cnt", i), Count, tv[i].cnt);
            chk($sformatf("tv%0d_emp", i), Empty, tv[i].emp);
            chk($sformatf("tv%0d_ae", i), AlmostEmpty, tv[i].ae);
        end
        chk("basic_parerr", ParErr, 0);

        // Fill to full, watching AlmostFull and Full thresholds.
        for (int i = 0; i < 1024; i++) begin
            cyc(1'b1, 1'b0, 32'hA5A50000 + 32'(i), 4'h0, 1'b0);
            chk($sformatf("fill%0d_af", i), AlmostFull, (i + 1) >= 1020);
            chk($sformatf("fill%0d_full", i), Full, (i + 1) == 1024);
        end
        chk("fill_count", Count, 1024);
        chk("fill_ovf_none", Overflow, 0);
        cyc(1'b1, 1'b0, 32'hFFFFFFFF, 4'h0, 1'b0);
        chk("ovf_pulse", Overflow, 1);
        chk("ovf_count", Count, 1024);
        cyc(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        chk("ovf_one_cycle", Overflow, 0);

        // Simultaneous read/write while full.
        cyc(1'b1, 1'b1, 32'h11111111, 4'h0, 1'b0);
        chk("fullrw_q", Q, 32'hA5A50000);
        chk("fullrw_edo", EDO, ref_par(32'hA5A50000));
        chk("fullrw_qv", QValid, 1);
        chk("fullrw_ovf", Overflow, 1);
        chk("fullrw_cnt", Count, 1023);
        chk("fullrw_full", Full, 0);
        for (int i = 1; i < 1024; i++) begin
            cyc(1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
            chk($sformatf("drain%0d_q", i), Q, 32'hA5A50000 + 32'(i));
        end
        chk("drain_empty", Empty, 1);
        chk("drain_cnt", Count, 0);

        // Simultaneous read/write while empty.
        cyc(1'b1, 1'b1, 32'hDEADBEEF, 4'h0, 1'b0);
        chk("emptyrw_unf", Underflow, 1);
        chk("emptyrw_qv", QValid, 0);
        chk("emptyrw_cnt", Count, 1);
        cyc(1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
        chk("emptyrw_q", Q, 32'hDEADBEEF);
        chk("emptyrw_qv2", QValid, 1);
        chk("emptyrw_unf2", Underflow, 0);

        // Parity error injection on lane 2, sticky until ClrErr.
        cyc(1'b1, 1'b0, 32'h12345678, 4'b0100, 1'b0);
        cyc(1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
        chk("par_q", Q, 32'h12345678);
        chk("par_edo", EDO, ref_par(32'h12345678) ^ 4'b0100);
        cyc(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        chk("par_lane", ParErrLane, 4'b0100);
        chk("par_err", ParErr, 1);
        cyc(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        chk("par_sticky", {ParErr, ParErrLane}, {1'b1, 4'b0100});
        cyc(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
        chk("par_clr", {ParErr, ParErrLane}, 0);
        cyc(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);

        // Random interleaved traffic against a queue model.
        for (int i = 0; i < 3000; i++) begin
            pw = (i < 1500) ? 85 : 40;
            pr = (i < 1500) ? 35 : 80;
            wr = $urandom_range(99) < pw;
            rd = $urandom_range(99) < pr;
            d  = $urandom;
            wacc = wr && (mq.size() < 1024);
            racc = rd && (mq.size() > 0);
            chk("rnd_ovf_pre", Overflow & 1'b0, 0);
            n_chk--;
            cyc(wr, rd, d, 4'h0, 1'b0);
            chk($sformatf("rnd%0d_unf", i), Underflow, rd && !racc);
            chk($sformatf("rnd%0d_ovf", i), Overflow, wr && !wacc);
            if (racc) begin
                expq = mq.pop_front();
                chk($sformatf("rnd%0d_q", i), Q, expq);
            end
            if (wacc) mq.push_back(d);
            chk($sformatf("rnd%0d_qv", i), QValid, racc);
            chk($sformatf("rnd%0d_cnt", i), Count, mq.size());
            chk($sformatf("rnd%0d_flags", i), {Full, Empty}, {mq.size() == 1024, mq.size() == 0});
        end
        chk("rnd_parerr", ParErr, 0);

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'hC0DE0000 + 32'(i), 4'h0, 1'b0);
        WrEn = 1'b0; RdEn = 1'b0;
        #2 ResetN = 1'b0;
        #1;
        chk("arst_cnt", Count, 0);
        chk("arst_empty", Empty, 1);
        chk("arst_q", Q, 0);
        chk("arst_qv", QValid, 0);
        #2 ResetN = 1'b1;
        cyc(1'b1, 1'b0, 32'h00000055, 4'h0, 1'b0);
        chk("post_rst_cnt", Count, 1);
        cyc(1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
        chk("post_rst_q", Q, 32'h00000055);
        chk("post_rst_empty", Empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
